// File: rtl/rv32i_controller_if.sv
// rv32i_controller_if: imem/dmem handshakes plus datapath control bundle.
// master = controller side, slave = memories and datapath side.
interface rv32i_controller_if;
  logic [31:0] inst;
  logic        imemReady;
  logic        dmemReady;
  logic        aluZero;
  logic        aluLt;
  logic        aluLtu;
  logic        imemReq;
  logic        dmemReq;
  logic        dmemWE;
  logic        irWE;
  logic        pcWE;
  logic        regWE;
  logic [1:0]  rs1sel;
  logic [1:0]  rs2sel;
  logic [1:0]  regsel;
  logic [1:0]  PCsel;
  logic [2:0]  ImmSel;
  logic [3:0]  ALUControl;
  logic        trap;
  logic [31:0] instret;

  modport master (
    input  inst, imemReady, dmemReady,
    input  aluZero, aluLt, aluLtu,
    output imemReq, dmemReq, dmemWE,
    output irWE, pcWE, regWE,
    output rs1sel, rs2sel, regsel, PCsel,
    output ImmSel, ALUControl,
    output trap, instret
  );

  modport slave (
    output inst, imemReady, dmemReady,
    output aluZero, aluLt, aluLtu,
    input  imemReq, dmemReq, dmemWE,
    input  irWE, pcWE, regWE,
    input  rs1sel, rs2sel, regsel, PCsel,
    input  ImmSel, ALUControl,
    input  trap, instret
  );
endinterface

// File: rtl/rv32i_controller.sv
// rv32i_controller: multi-cycle RV32I sequencer, FETCH/DECODE/EXEC/MEM/WB.
// Define RV32I_INSTRET_EN to build the retired-instruction counter.
module rv32i_controller #(
  parameter int MEM_WAIT_MAX = 255
) (
  input logic clk,
  input logic reset,
  rv32i_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NOP   = 4'd0,
    C_LUI   = 4'd1,
    C_AUIPC = 4'd2,
    C_JAL   = 4'd3,
    C_JALR  = 4'd4,
    C_BR    = 4'd5,
    C_LD    = 4'd6,
    C_ST    = 4'd7,
    C_OPI   = 4'd8,
    C_OP    = 4'd9
  } cls_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ST     = 7'b0100011;
  localparam logic [6:0] OP_OPI    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RS_DMEM = 2'd0;
  localparam logic [1:0] RS_ALU  = 2'd1;
  localparam logic [1:0] RS_IMM  = 2'd2;
  localparam logic [1:0] RS_PC4  = 2'd3;

  localparam logic [1:0] PC_4   = 2'd0;
  localparam logic [1:0] PC_ALU = 2'd1;
  localparam logic [1:0] PC_IMM = 2'd2;

  localparam logic [8:0] LP_WAIT_MAX = 9'(MEM_WAIT_MAX);

  state_t      r_state;
  cls_t        r_cls;
  logic [6:0]  r_op;
  logic [2:0]  r_f3;
  logic        r_f7b;
  logic [7:0]  r_stall;
  logic        r_imemReq;
  logic        r_dmemReq;
  logic        r_dmemWE;
  logic        r_irWE;
  logic        r_pcWE;
  logic        r_regWE;
  logic        r_trap;
  logic [1:0]  r_rs1sel;
  logic [1:0]  r_rs2sel;
  logic [1:0]  r_regsel;
  logic [1:0]  r_PCsel;
  logic [2:0]  r_ImmSel;
  logic [3:0]  r_ALUControl;

  logic        w_is_lui;
  logic        w_is_auipc;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_br;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_opi;
  logic        w_is_op;
  logic        w_is_sys;
  logic        w_valid;
  cls_t        w_cls;
  logic [3:0]  w_alu;
  logic [3:0]  w_alu_f3;
  logic [2:0]  w_imm;
  logic [1:0]  w_rs1sel;
  logic [1:0]  w_rs2sel;
  logic [1:0]  w_regsel;
  logic        w_take;
  logic [1:0]  w_pcsel;
  logic [8:0]  w_stall_inc;
  logic        w_stall_hit;
  logic [7:0]  w_stall_sat;
  logic        w_unused;

  // Only opcode, funct3 and funct7[5] steer control; the rest is datapath's.
  assign w_unused = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7]};

  assign w_is_lui   = (r_op == OP_LUI);
  assign w_is_auipc = (r_op == OP_AUIPC);
  assign w_is_jal   = (r_op == OP_JAL);
  assign w_is_jalr  = (r_op == OP_JALR);
  assign w_is_br    = (r_op == OP_BR);
  assign w_is_ld    = (r_op == OP_LD);
  assign w_is_st    = (r_op == OP_ST);
  assign w_is_opi   = (r_op == OP_OPI);
  assign w_is_op    = (r_op == OP_OP);
  assign w_is_sys   = (r_op == OP_FENCE) || (r_op == OP_SYSTEM);

  assign w_stall_inc = {1'b0, r_stall} + 9'd1;
  assign w_stall_hit = (w_stall_inc >= LP_WAIT_MAX);
  assign w_stall_sat = (r_stall == 8'hFF) ? r_stall : r_stall + 8'd1;

  // ALU op for register and immediate arithmetic from funct3/funct7[5]
  always_comb begin
    w_alu_f3 = ALU_ADD;
    unique case (r_f3)
      3'd0: w_alu_f3 = (w_is_op && r_f7b) ? ALU_SUB : ALU_ADD;
      3'd1: w_alu_f3 = ALU_SLL;
      3'd2: w_alu_f3 = ALU_SLT;
      3'd3: w_alu_f3 = ALU_SLTU;
      3'd4: w_alu_f3 = ALU_XOR;
      3'd5: w_alu_f3 = r_f7b ? ALU_SRA : ALU_SRL;
      3'd6: w_alu_f3 = ALU_OR;
      3'd7: w_alu_f3 = ALU_AND;
    endcase
  end

  // Instruction class, legality and datapath selects
  always_comb begin
    w_valid  = 1'b0;
    w_cls    = C_NOP;
    w_alu    = ALU_ADD;
    w_imm    = IMM_I;
    w_rs1sel = 2'd0;
    w_rs2sel = 2'd0;
    w_regsel = RS_DMEM;
    unique case (1'b1)
      w_is_lui: begin
        w_valid  = 1'b1;
        w_cls    = C_LUI;
        w_imm    = IMM_U;
        w_regsel = RS_IMM;
      end
      w_is_auipc: begin
        w_valid  = 1'b1;
        w_cls    = C_AUIPC;
        w_imm    = IMM_U;
        w_rs1sel = 2'd1;
        w_rs2sel = 2'd1;
        w_regsel = RS_ALU;
      end
      w_is_jal: begin
        w_valid  = 1'b1;
        w_cls    = C_JAL;
        w_imm    = IMM_J;
        w_regsel = RS_PC4;
      end
      w_is_jalr: begin
        w_valid  = (r_f3 == 3'd0);
        w_cls    = C_JALR;
        w_rs2sel = 2'd1;
        w_regsel = RS_PC4;
      end
      w_is_br: begin
        w_valid  = (r_f3 != 3'd2) && (r_f3 != 3'd3);
        w_cls    = C_BR;
        w_imm    = IMM_B;
        w_alu    = ALU_SUB;
      end
      w_is_ld: begin
        w_valid  = (r_f3 != 3'd3) && (r_f3 != 3'd6) &&
                   (r_f3 != 3'd7);
        w_cls    = C_LD;
        w_rs2sel = 2'd1;
      end
      w_is_st: begin
        w_valid  = (r_f3 <= 3'd2);
        w_cls    = C_ST;
        w_imm    = IMM_S;
        w_rs2sel = 2'd1;
      end
      w_is_opi: begin
        w_valid  = !((r_f3 == 3'd1) && r_f7b);
        w_cls    = C_OPI;
        w_alu    = w_alu_f3;
        w_rs2sel = 2'd1;
        w_regsel = RS_ALU;
      end
      w_is_op: begin
        w_valid  = !r_f7b || (r_f3 == 3'd0) || (r_f3 == 3'd5);
        w_cls    = C_OP;
        w_alu    = w_alu_f3;
        w_regsel = RS_ALU;
      end
      w_is_sys: begin
        w_valid  = 1'b1;
        w_cls    = C_NOP;
      end
      default: begin
        w_valid  = 1'b0;
      end
    endcase
  end

  // Branch condition from the datapath comparison flags
  always_comb begin
    w_take = 1'b0;
    unique case (r_f3)
      3'd0:    w_take = bus.aluZero;
      3'd1:    w_take = !bus.aluZero;
      3'd4:    w_take = bus.aluLt;
      3'd5:    w_take = !bus.aluLt;
      3'd6:    w_take = bus.aluLtu;
      3'd7:    w_take = !bus.aluLtu;
      default: w_take = 1'b0;
    endcase
  end

  // Next-PC source committed in WB
  always_comb begin
    w_pcsel = PC_4;
    if (r_cls == C_JAL)
      w_pcsel = PC_IMM;
    else if (r_cls == C_JALR)
      w_pcsel = PC_ALU;
    else if ((r_cls == C_BR) && w_take)
      w_pcsel = PC_IMM;
  end

  // Sequencer with registered control outputs and memory stall watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_cls        <= C_NOP;
      r_op         <= 7'd0;
      r_f3         <= 3'd0;
      r_f7b        <= 1'b0;
      r_stall      <= 8'd0;
      r_imemReq    <= 1'b0;
      r_dmemReq    <= 1'b0;
      r_dmemWE     <= 1'b0;
      r_irWE       <= 1'b0;
      r_pcWE       <= 1'b0;
      r_regWE      <= 1'b0;
      r_trap       <= 1'b0;
      r_rs1sel     <= 2'd0;
      r_rs2sel     <= 2'd0;
      r_regsel     <= 2'd0;
      r_PCsel      <= 2'd0;
      r_ImmSel     <= 3'd0;
      r_ALUControl <= 4'd0;
    end else begin
      r_irWE  <= 1'b0;
      r_pcWE  <= 1'b0;
      r_regWE <= 1'b0;
      unique case (r_state)
        S_FETCH: begin
          if (r_imemReq && bus.imemReady) begin
            r_imemReq <= 1'b0;
            r_irWE    <= 1'b1;
            r_op      <= bus.inst[6:0];
            r_f3      <= bus.inst[14:12];
            r_f7b     <= bus.inst[30];
            r_stall   <= 8'd0;
            r_state   <= S_DECODE;
          end else if (r_imemReq) begin
            r_stall <= w_stall_sat;
            if (w_stall_hit) begin
              r_imemReq <= 1'b0;
              r_trap    <= 1'b1;
              r_state   <= S_TRAP;
            end
          end else begin
            r_imemReq <= 1'b1;
          end
        end
        S_DECODE: begin
          if (!w_valid) begin
            r_trap  <= 1'b1;
            r_state <= S_TRAP;
          end else begin
            r_cls        <= w_cls;
            r_ALUControl <= w_alu;
            r_ImmSel     <= w_imm;
            r_rs1sel     <= w_rs1sel;
            r_rs2sel     <= w_rs2sel;
            r_regsel     <= w_regsel;
            r_PCsel      <= PC_4;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if ((r_cls == C_LD) || (r_cls == C_ST)) begin
            r_dmemReq <= 1'b1;
            r_dmemWE  <= (r_cls == C_ST);
            r_state   <= S_MEM;
          end else begin
            r_regWE <= (r_cls != C_BR) && (r_cls != C_NOP);
            r_pcWE  <= 1'b1;
            r_PCsel <= w_pcsel;
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmemReady) begin
            r_dmemReq <= 1'b0;
            r_dmemWE  <= 1'b0;
            r_stall   <= 8'd0;
            r_regWE   <= (r_cls == C_LD);
            r_pcWE    <= 1'b1;
            r_PCsel   <= PC_4;
            r_state   <= S_WB;
          end else begin
            r_stall <= w_stall_sat;
            if (w_stall_hit) begin
              r_dmemReq <= 1'b0;
              r_dmemWE  <= 1'b0;
              r_trap    <= 1'b1;
              r_state   <= S_TRAP;
            end
          end
        end
        S_WB: begin
          r_imemReq <= 1'b1;
          r_state   <= S_FETCH;
        end
        S_TRAP: begin
          r_imemReq <= 1'b0;
          r_dmemReq <= 1'b0;
          r_dmemWE  <= 1'b0;
          r_trap    <= 1'b1;
        end
        default: begin
          r_imemReq <= 1'b0;
          r_dmemReq <= 1'b0;
          r_dmemWE  <= 1'b0;
          r_trap    <= 1'b1;
          r_state   <= S_TRAP;
        end
      endcase
    end
  end

  assign bus.imemReq    = r_imemReq;
  assign bus.dmemReq    = r_dmemReq;
  assign bus.dmemWE     = r_dmemWE;
  assign bus.irWE       = r_irWE;
  assign bus.pcWE       = r_pcWE;
  assign bus.regWE      = r_regWE;
  assign bus.rs1sel     = r_rs1sel;
  assign bus.rs2sel     = r_rs2sel;
  assign bus.regsel     = r_regsel;
  assign bus.PCsel      = r_PCsel;
  assign bus.ImmSel     = r_ImmSel;
  assign bus.ALUControl = r_ALUControl;
  assign bus.trap       = r_trap;

`ifdef RV32I_INSTRET_EN
  logic [31:0] r_instret;

  // One retirement per WB cycle, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_instret <= 32'd0;
    else if (r_state == S_WB)
      r_instret <= r_instret + 32'd1;
  end

  assign bus.instret = r_instret;
`else
  assign bus.instret = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_controller.sv
// tb_rv32i_controller: directed plus random instruction stream checked
// against a per-instruction control model.
module tb_rv32i_controller;

  localparam int MAXW = 255;
  localparam int ALUT [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam logic [6:0] OPS [11] = '{
    7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
    7'h23, 7'h13, 7'h33, 7'h0F, 7'h73
  };

  typedef struct packed {
    logic       valid;
    logic       mem;
    logic       st;
    logic       wr;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [1:0] rsel;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  int   retired;

  rv32i_controller_if bus();

  rv32i_controller #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] arith_alu(input int f3, input bit f7,
                                           input bit is_op);
    if (f3 == 5) return f7 ? 4'd7 : 4'd6;
    if (f3 == 0 && f7 && is_op) return 4'd1;
    return 4'(ALUT[f3]);
  endfunction

  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    int   f3;
    bit   f7;
    f3 = int'(i[14:12]);
    f7 = i[30];
    e = '0;
    e.valid = 1'b1;
    e.wr = 1'b1;
    case (i[6:0])
      7'h37: begin e.imm = 3'd3; e.rsel = 2'd2; end
      7'h17: begin
        e.imm = 3'd3; e.rs1 = 2'd1; e.rs2 = 2'd1; e.rsel = 2'd1;
      end
      7'h6F: begin e.imm = 3'd4; e.rsel = 2'd3; end
      7'h67: begin
        e.valid = (f3 == 0); e.rs2 = 2'd1; e.rsel = 2'd3;
      end
      7'h63: begin
        e.valid = !(f3 == 2 || f3 == 3);
        e.wr = 1'b0; e.imm = 3'd2; e.alu = 4'd1;
      end
      7'h03: begin
        e.valid = (f3 inside {0, 1, 2, 4, 5});
        e.mem = 1'b1; e.rs2 = 2'd1;
      end
      7'h23: begin
        e.valid = (f3 <= 2); e.mem = 1'b1; e.st = 1'b1;
        e.wr = 1'b0; e.rs2 = 2'd1; e.imm = 3'd1;
      end
      7'h13: begin
        e.valid = !(f3 == 1 && f7); e.rs2 = 2'd1; e.rsel = 2'd1;
        e.alu = arith_alu(f3, f7, 1'b0);
      end
      7'h33: begin
        e.valid = !f7 || f3 == 0 || f3 == 5; e.rsel = 2'd1;
        e.alu = arith_alu(f3, f7, 1'b1);
      end
      7'h0F, 7'h73: e.wr = 1'b0;
      default: e.valid = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [1:0] model_pcsel(input logic [31:0] i,
                                             input bit z, input bit lt,
                                             input bit ltu);
    bit c;
    if (i[6:0] == 7'h6F) return 2'd2;
    if (i[6:0] == 7'h67) return 2'd1;
    if (i[6:0] != 7'h63) return 2'd0;
    case (i[14:12])
      3'd0: c = z;
      3'd1: c = !z;
      3'd4: c = lt;
      3'd5: c = !lt;
      3'd6: c = ltu;
      default: c = !ltu;
    endcase
    return c ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [63:0] all_outs();
    return {10'd0, bus.imemReq, bus.dmemReq, bus.dmemWE, bus.irWE,
            bus.pcWE, bus.regWE, bus.rs1sel, bus.rs2sel, bus.regsel,
            bus.PCsel, bus.ImmSel, bus.ALUControl, bus.trap,
            bus.instret};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.imemReady = 1'b1;
    bus.dmemReady = 1'b0;
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_hold", all_outs(), 64'd0);
    reset = 1'b0;
    retired = 0;
    #2;
    chk("idle_after_rst", {63'd0, bus.imemReq}, 64'd0);
    tick();
    chk("first_req", {bus.imemReq, bus.irWE}, 2'b10);
  endtask

  task automatic do_instr(input logic [31:0] ins, input int iw,
                          input int dw, input bit z, input bit lt,
                          input bit ltu, input bit rst_in_mem);
    exp_t        e;
    logic [1:0]  pcs;
    logic [12:0] sel;
    logic [31:0] exp_ir;
    e = model(ins);
    pcs = model_pcsel(ins, z, lt, ltu);
    sel = {e.alu, e.imm, e.rs1, e.rs2, e.rsel};
    bus.aluZero = !z;
    bus.aluLt = !lt;
    bus.aluLtu = !ltu;
    chk("fetch_req", {bus.imemReq, bus.regWE, bus.pcWE}, 3'b100);
    bus.inst = ins;
    bus.imemReady = 1'b0;
    for (int k = 0; k < iw; k++) begin
      tick();
      chk("fetch_wait", {bus.imemReq, bus.irWE}, 2'b10);
    end
    bus.imemReady = 1'b1;
    tick();
    bus.imemReady = 1'b0;
    bus.inst = $urandom();
    chk("decode_irwe", {bus.irWE, bus.imemReq, bus.regWE, bus.pcWE},
        4'b1000);
    tick();
    if (!e.valid) begin
      chk("trap_set", {bus.trap, bus.imemReq, bus.irWE}, 3'b100);
      bus.imemReady = 1'b1;
      bus.dmemReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("trap_stay", {bus.trap, bus.imemReq, bus.dmemReq, bus.irWE,
                          bus.regWE, bus.pcWE}, 6'b100000);
      end
      do_reset();
      chk("trap_clear", {bus.trap}, 1'b0);
      return;
    end
    chk("exec_sel", {bus.ALUControl, bus.ImmSel, bus.rs1sel, bus.rs2sel,
                     bus.regsel}, sel);
    chk("exec_en", {bus.irWE, bus.regWE, bus.pcWE, bus.dmemReq}, 4'd0);
    bus.aluZero = z;
    bus.aluLt = lt;
    bus.aluLtu = ltu;
    tick();
    if (e.mem) begin
      for (int k = 0; k <= dw; k++) begin
        chk("mem_req", {bus.dmemReq, bus.dmemWE, bus.regWE, bus.pcWE},
            {1'b1, e.st, 2'b00});
        chk("mem_sel", {bus.ALUControl, bus.ImmSel, bus.rs1sel,
                        bus.rs2sel, bus.regsel}, sel);
        if (rst_in_mem) begin
          #2;
          reset = 1'b1;
          #1;
          chk("rst_mid_mem", {bus.dmemReq, bus.dmemWE, bus.regWE,
                              bus.pcWE}, 4'd0);
          do_reset();
          return;
        end
        bus.dmemReady = (k == dw);
        tick();
      end
      bus.dmemReady = 1'b0;
    end
    chk("wb_ctl", {bus.regWE, bus.pcWE, bus.PCsel, bus.regsel,
                   bus.dmemReq, bus.irWE, bus.imemReq},
        {e.wr, 1'b1, pcs, e.rsel, 3'b000});
    retired++;
    tick();
    bus.aluZero = 1'($urandom());
    bus.aluLt = 1'($urandom());
    bus.aluLtu = 1'($urandom());
    chk("next_fetch", {bus.imemReq, bus.regWE, bus.pcWE}, 3'b100);
`ifdef RV32I_INSTRET_EN
    exp_ir = 32'(retired);
`else
    exp_ir = 32'd0;
`endif
    chk("instret", {32'd0, bus.instret}, {32'd0, exp_ir});
  endtask

  initial begin
    logic [31:0] ins;
    int          pick;
    clk = 1'b0;
    reset = 1'b1;
    n_chk = 0;
    n_err = 0;
    retired = 0;
    bus.inst = 32'd0;
    bus.imemReady = 1'b0;
    bus.dmemReady = 1'b0;
    bus.aluZero = 1'b0;
    bus.aluLt = 1'b0;
    bus.aluLtu = 1'b0;
    #3;
    do_reset();

    do_instr(32'h00500093, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0000a103, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0020a223, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h00208463, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0080006F, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h000080E7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h40208133, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h4020D193, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h00000073, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_instr(32'h0000a103, 0, 5, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 120; n++) begin
      ins = $urandom();
      pick = int'($urandom_range(0, 11));
      ins[6:0] = (pick == 11) ? 7'h7F : OPS[pick];
      ins[30] = ($urandom_range(0, 3) == 0);
      do_instr(ins, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom()),
               1'($urandom()), 1'($urandom()), 1'b0);
    end

    do_reset();
    bus.imemReady = 1'b0;
    repeat (MAXW - 1) tick();
    chk("stall_no_trap", {bus.trap, bus.imemReq}, 2'b01);
    tick();
    chk("stall_trap", {bus.trap, bus.imemReq}, 2'b10);
    do_reset();
    chk("stall_trap_clr", {bus.trap}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
